// File: rtl/v_instr_queue_pkg.sv
// Shared types and constants for the vector instruction queue.
package v_instr_queue_pkg;

    localparam int unsigned VIQ_DEPTH_DEFAULT = 4;
    localparam int unsigned VIQ_XLEN          = 32;
    localparam int unsigned VIQ_ILEN          = 32;

    localparam logic [6:0] OPC_RTYPE = 7'h57;
    localparam logic [6:0] OPC_LTYPE = 7'h07;
    localparam logic [6:0] OPC_STYPE = 7'h27;

    typedef struct packed {
        logic [VIQ_ILEN-1:0] instr;
        logic [VIQ_XLEN-1:0] rs1;
        logic [VIQ_XLEN-1:0] rs2;
    } viq_entry_t;

    // True for the major opcodes the vector decoder understands.
    function automatic logic is_vec_opcode(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_LTYPE) || (opc == OPC_STYPE);
    endfunction

endpackage

// File: rtl/v_instr_queue_if.sv
// Issue-side and decoder-side handshake bundle of the vector instruction queue.
interface v_instr_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_rs1;
    logic [XLEN-1:0] out_rs2;

    modport master (
        output in_valid, in_instr, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_instr, out_rs1, out_rs2
    );

    modport slave (
        input  in_valid, in_instr, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_instr, out_rs1, out_rs2
    );
endinterface

// File: rtl/v_instr_queue_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module v_viq_mem
    import v_instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = VIQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  viq_entry_t               i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output viq_entry_t               o_rdata
);

    viq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/v_instr_queue.sv
// Vector instruction queue between scalar issue and the vector decoder; drops non-vector opcodes.
// Optional same-cycle empty-queue bypass enabled by defining VIQ_BYPASS_EN.
module v_instr_queue
    import v_instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = VIQ_DEPTH_DEFAULT,
    parameter int unsigned XLEN  = VIQ_XLEN
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   flush,
    v_instr_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   illegal,
    output logic                   busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_illegal;

    logic       w_empty;
    logic       w_full;
    logic       w_legal;
    logic       w_bypass;
    logic       w_push_hs;
    logic       w_pop_hs;
    logic       w_wr_en;
    logic       w_rd_en;
    viq_entry_t w_wr_entry;
    viq_entry_t w_rd_entry;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_legal = is_vec_opcode(bus.in_instr[6:0]);

`ifdef VIQ_BYPASS_EN
    assign w_bypass = w_empty && bus.in_valid && w_legal && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // in_ready looks only at the registered count, never at out_ready.
    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty || w_bypass;

    assign w_push_hs = bus.in_valid && !w_full;
    assign w_pop_hs  = bus.out_valid && bus.out_ready;
    // A bypassed instruction taken by the decoder in the same cycle never lands in storage.
    assign w_wr_en   = w_push_hs && w_legal && !(w_bypass && bus.out_ready);
    assign w_rd_en   = w_pop_hs && !w_empty;

    assign w_wr_entry.instr = bus.in_instr;
    assign w_wr_entry.rs1   = VIQ_XLEN'(bus.in_rs1);
    assign w_wr_entry.rs2   = VIQ_XLEN'(bus.in_rs2);

    v_viq_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_tail),
        .i_wdata (w_wr_entry),
        .i_raddr (r_head),
        .o_rdata (w_rd_entry)
    );

    // Head presentation: bypass input, stored head, or zeros when empty.
    always_comb begin
        bus.out_instr = '0;
        bus.out_rs1   = '0;
        bus.out_rs2   = '0;
        if (w_bypass) begin
            bus.out_instr = bus.in_instr;
            bus.out_rs1   = bus.in_rs1;
            bus.out_rs2   = bus.in_rs2;
        end else if (!w_empty) begin
            bus.out_instr = w_rd_entry.instr;
            bus.out_rs1   = XLEN'(w_rd_entry.rs1);
            bus.out_rs2   = XLEN'(w_rd_entry.rs2);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_rd_en) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_illegal <= w_push_hs && !w_legal;
        end
    end

    assign count   = r_count;
    assign illegal = r_illegal;
    assign busy    = !w_empty;

endmodule

// File: tb/tb_v_instr_queue.sv
// Self-checking bench for v_instr_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_v_instr_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } ent_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic       flush;
    logic [2:0] count;
    logic       illegal;
    logic       busy;

    v_instr_queue_if #(.XLEN(XLEN)) bus ();

    v_instr_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .flush   (flush),
        .bus     (bus),
        .count   (count),
        .illegal (illegal),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    ent_t m_q[$];
    logic m_ill;
    int   total;
    int   bad;

    function automatic logic legal_opc(input logic [31:0] ins);
        logic [6:0] o;
        o = ins[6:0];
        return (o == 7'h57) || (o == 7'h07) || (o == 7'h27);
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(2))
            0:       r[6:0] = 7'h57;
            1:       r[6:0] = 7'h07;
            default: r[6:0] = 7'h27;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [31:0] r;
        r = $urandom();
        if (legal_opc(r)) r[6:0] = 7'h13;
        return r;
    endfunction

    function automatic logic m_byp();
`ifdef VIQ_BYPASS_EN
        return (m_q.size() == 0) && bus.in_valid && legal_opc(bus.in_instr) && !flush;
`else
        return 1'b0;
`endif
    endfunction

    function automatic ent_t m_head();
        if (m_q.size() != 0) return m_q[0];
        if (m_byp()) return {bus.in_instr, bus.in_rs1, bus.in_rs2};
        return '0;
    endfunction

    // Advance one clock, applying the queue rules to the model first.
    task automatic tick();
        int   n;
        logic byp, ovalid, pop, hs, leg;
        ent_t e;
        n      = m_q.size();
        byp    = m_byp();
        ovalid = (n != 0) || byp;
        pop    = ovalid && bus.out_ready;
        hs     = bus.in_valid && (n < DEPTH);
        leg    = legal_opc(bus.in_instr);
        e      = {bus.in_instr, bus.in_rs1, bus.in_rs2};
        if (!nrst || flush) begin
            m_q.delete();
            m_ill = 1'b0;
        end else begin
            if (pop && n != 0) void'(m_q.pop_front());
            if (hs && leg && !(byp && bus.out_ready)) m_q.push_back(e);
            m_ill = hs && !leg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_rs1    = a;
        bus.in_rs2    = b;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        nrst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
        total++; if ({busy, illegal} !== 2'b00) begin bad++; $display("FAIL reset_busy_illegal: got %b want 00", {busy, illegal}); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] ins [4];
        logic [31:0] r2  [4];
        ins = '{32'h0200_8057, 32'h0200_6007, 32'h0A00_4057, 32'h0000_7057};
        for (int i = 0; i < 4; i++) begin
            r2[i] = $urandom();
            drive(1'b1, ins[i], 32'h100 + 32'(i), r2[i], 1'b0, 1'b0);
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            tick();
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if ({bus.in_ready, bus.out_valid, busy} !== 3'b011) begin bad++; $display("FAIL full_flags: got %b want 011", {bus.in_ready, bus.out_valid, busy}); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
            total++; if ({bus.out_valid, bus.out_instr, bus.out_rs1, bus.out_rs2} !== {1'b1, ins[i], 32'h100 + 32'(i), r2[i]}) begin
                bad++; $display("FAIL drain_head[%0d]: got v=%b %h %h %h want v=1 %h %h %h", i, bus.out_valid, bus.out_instr, bus.out_rs1, bus.out_rs2, ins[i], 32'h100 + 32'(i), r2[i]);
            end
            tick();
            total++; if (count !== 3'(3 - i)) begin bad++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 3 - i); end
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if ({bus.out_valid, bus.out_instr, bus.out_rs1, bus.out_rs2} !== 97'h0) begin bad++; $display("FAIL empty_outputs: got v=%b %h %h %h want zeros", bus.out_valid, bus.out_instr, bus.out_rs1, bus.out_rs2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c;
        a = rand_legal(); b = rand_legal(); c = rand_legal();
        drive(1'b1, a, 32'h1, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, b, 32'h2, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, c, 32'h3, 32'h0, 1'b1, 1'b0);
        total++; if (bus.out_instr !== a) begin bad++; $display("FAIL b2b_first: got %h want %h", bus.out_instr, a); end
        tick();
        total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", count); end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if (bus.out_instr !== b) begin bad++; $display("FAIL b2b_second: got %h want %h", bus.out_instr, b); end
        tick();
        total++; if ({bus.out_instr, bus.out_rs1} !== {c, 32'h3}) begin bad++; $display("FAIL b2b_third: got %h/%h want %h/3", bus.out_instr, bus.out_rs1, c); end
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_drained: got %0d want 0", count); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h0000_0033, 32'h5, 32'h6, 1'b0, 1'b0);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL illegal_in_ready: got %b want 1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if ({illegal, count, bus.out_valid} !== {1'b1, 3'd0, 1'b0}) begin bad++; $display("FAIL illegal_pulse: got ill=%b cnt=%0d v=%b want ill=1 cnt=0 v=0", illegal, count, bus.out_valid); end
        tick();
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_one_cycle: got %b want 0", illegal); end
    endtask

    task automatic test_full_boundary();
        logic [31:0] x;
        for (int i = 0; i < 4; i++) begin drive(1'b1, rand_legal(), $urandom(), $urandom(), 1'b0, 1'b0); tick(); end
        x = rand_legal();
        drive(1'b1, x, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_in_ready: got %b want 0", bus.in_ready); end
        tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count: got %0d want 3", count); end
        drive(1'b1, rand_legal(), 32'h0, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0000_0033, 32'h0, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if ({illegal, count} !== {1'b0, 3'd4}) begin bad++; $display("FAIL full_illegal_ignored: got ill=%b cnt=%0d want ill=0 cnt=4", illegal, count); end
        for (int i = 0; i < 4; i++) begin
            ent_t e;
            drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
            e = m_head();
            total++; if ({bus.out_instr, bus.out_rs1, bus.out_rs2} !== e) begin bad++; $display("FAIL full_drain[%0d]: got %h %h %h want %h", i, bus.out_instr, bus.out_rs1, bus.out_rs2, e); end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin drive(1'b1, rand_legal(), $urandom(), $urandom(), 1'b0, 1'b0); tick(); end
        drive(1'b1, rand_legal(), 32'h7, 32'h8, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if ({count, bus.out_valid, busy, bus.out_instr} !== 37'h0) begin bad++; $display("FAIL flush_empty: got cnt=%0d v=%b busy=%b ins=%h want all 0", count, bus.out_valid, busy, bus.out_instr); end
        drive(1'b1, rand_legal(), 32'h0, 32'h0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h0000_0033, 32'h0, 32'h0, 1'b0, 1'b1); tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if ({illegal, count} !== 4'h0) begin bad++; $display("FAIL flush_illegal_suppressed: got ill=%b cnt=%0d want 0 0", illegal, count); end
        d = rand_legal();
        drive(1'b1, d, 32'hABCD, 32'h1234, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if ({count, bus.out_instr, bus.out_rs1} !== {3'd1, d, 32'hABCD}) begin bad++; $display("FAIL flush_after_push: got cnt=%0d %h %h want 1 %h abcd", count, bus.out_instr, bus.out_rs1, d); end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        while (got.size() < 10 && cyc < 100) begin
            logic v;
            v = (sent < 10);
            drive(v, 32'h57 | (32'(sent) << 7), 32'h200 + 32'(sent), 32'h0, 1'b1, 1'b0);
            if (bus.out_valid === 1'b1) got.push_back(bus.out_instr);
            if (v && bus.in_ready === 1'b1) sent++;
            tick();
            cyc++;
        end
        total++; if (got.size() != 10) begin bad++; $display("FAIL wrap_received: got %0d entries want 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            total++; if (got[i] !== (32'h57 | (32'(i) << 7))) begin bad++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], 32'h57 | (32'(i) << 7)); end
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_final_count: got %0d want 0", count); end
    endtask

`ifdef VIQ_BYPASS_EN
    task automatic test_bypass();
        logic [31:0] x, y;
        x = rand_legal(); y = rand_legal();
        drive(1'b1, x, 32'h11, 32'h22, 1'b1, 1'b0);
        total++; if ({bus.out_valid, bus.out_instr, bus.out_rs1} !== {1'b1, x, 32'h11}) begin bad++; $display("FAIL bypass_same_cycle: got v=%b %h %h want 1 %h 11", bus.out_valid, bus.out_instr, bus.out_rs1, x); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if ({count, bus.out_valid} !== 4'h0) begin bad++; $display("FAIL bypass_consumed: got cnt=%0d v=%b want 0 0", count, bus.out_valid); end
        drive(1'b1, y, 32'h33, 32'h44, 1'b0, 1'b0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bypass_stall_valid: got %b want 1", bus.out_valid); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        total++; if ({count, bus.out_instr} !== {3'd1, y}) begin bad++; $display("FAIL bypass_stored: got cnt=%0d %h want 1 %h", count, bus.out_instr, y); end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ins;
            logic [3:0]  exp_flags;
            ent_t        exp_d;
            nrst = ($urandom_range(99) != 0);
            ins  = ($urandom_range(4) == 0) ? rand_illegal() : rand_legal();
            drive(1'($urandom_range(1)), ins, $urandom(), $urandom(),
                  ($urandom_range(9) < 4), ($urandom_range(39) == 0));
            exp_flags = {(m_q.size() != 0) || m_byp(), m_q.size() < DEPTH, m_q.size() != 0, m_ill};
            exp_d     = m_head();
            total++; if ({bus.out_valid, bus.in_ready, busy, illegal} !== exp_flags) begin bad++; $display("FAIL rand_flags[%0d]: got %b want %b", c, {bus.out_valid, bus.in_ready, busy, illegal}, exp_flags); end
            total++; if (count !== 3'(m_q.size())) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, count, m_q.size()); end
            total++; if ({bus.out_instr, bus.out_rs1, bus.out_rs2} !== exp_d) begin bad++; $display("FAIL rand_data[%0d]: got %h %h %h want %h", c, bus.out_instr, bus.out_rs1, bus.out_rs2, exp_d); end
            tick();
        end
        nrst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_ill = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_illegal();
        test_full_boundary();
        test_flush();
        test_wrap();
`ifdef VIQ_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/v_instr_queue.md
Name: v_instr_queue

Overview:
- Vector instruction queue between the scalar core's vector-issue port and the vector decoder.
- Buffers each 32-bit vector instruction together with its scalar operands (rs1/rs2 values) with valid/ready on both sides.
- Presents the head entry to the decoder and the operand-select muxes.
- Filters out non-vector opcodes so only OPC_RTYPE/OPC_LTYPE/OPC_STYPE instructions reach the decoder.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, width of scalar operand fields.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  synchronous active-low reset.
- flush  in  1  discard all queued entries.
- in_valid  in  1  scalar core presents an instruction.
- in_ready  out  1  queue can accept.
- in_instr  in  32  vector instruction word.
- in_rs1  in  XLEN  scalar rs1 value (base address, scalar operand, AVL).
- in_rs2  in  XLEN  scalar rs2 value (stride, vtype for vsetvl).
- out_valid  out  1  head entry valid for the decoder.
- out_ready  in  1  downstream consumes head.
- out_instr  out  32  head instruction; 0 when empty.
- out_rs1  out  XLEN  head rs1; 0 when empty.
- out_rs2  out  XLEN  head rs2; 0 when empty.
- count  out  $clog2(DEPTH)+1  occupied entries.
- illegal  out  1  one-cycle pulse: a non-vector opcode was accepted and dropped.
- busy  out  1  count != 0.

Behaviour:
- Clock is clk; reset is nrst, synchronous, active-low. On the reset edge: head/tail pointers = 0, count = 0, illegal = 0. Outputs then read out_valid = 0, out_instr/out_rs1/out_rs2 = 0, busy = 0, in_ready = 1. Reset mid-operation discards all entries.
- Push handshake: in_valid && in_ready. in_ready = (count < DEPTH). A full queue does not accept, even if a pop occurs in the same cycle; in_ready has no combinational path from out_ready.
- Opcode filter: a push whose in_instr[6:0] is not OPC_RTYPE, OPC_LTYPE or OPC_STYPE is consumed (handshake completes) but not stored. illegal is registered and goes high the following cycle for exactly one cycle.
- Pop handshake: out_valid && out_ready. out_valid = (count != 0). Head data is stable while out_valid && !out_ready.
- Latency: a stored push is visible at out_valid on the next cycle (1-cycle latency).
- Pointers wrap modulo DEPTH.
- Count update:
  - push-only: +1
  - pop-only: -1
  - simultaneous push and pop: count unchanged, tail and head both advance.
  - dropped illegal push: counts as no push.
- Empty: out_valid = 0, data outputs forced to 0.
- Full: in_ready = 0, count = DEPTH.
- flush (synchronous, priority below nrst): next cycle pointers = 0 and count = 0. Any same-cycle push or pop is ignored. A same-cycle illegal pulse is suppressed.
- Storage needs no reset; only pointers and count are reset.

Optional Feature:
- Macro VIQ_BYPASS_EN.
- Defined: when count == 0 and in_valid with a legal opcode, the input is forwarded combinationally to out_*. out_valid = 1 in the same cycle. If out_ready is also high the entry is consumed without being written (count stays 0); otherwise it is written normally. No bypass when flush = 1.
- Undefined: strict 1-cycle latency as above; out_* never depend combinationally on in_*.

Decomposition:
- v_pkg additions:
  - typedef struct packed viq_entry_t {instr[31:0], rs1[XLEN-1:0], rs2[XLEN-1:0]}
  - localparam VIQ_DEPTH_DEFAULT = 4
  - OPC_RTYPE/OPC_LTYPE/OPC_STYPE reused from v_pkg.
- One sub-module: v_viq_mem, a DEPTH x viq_entry_t register array with one write port and one async read port.
- Pointer/count/filter logic stays in v_instr_queue.

Test Plan:
- Reset then idle: nrst low for 2 cycles -> out_valid=0, count=0, in_ready=1, out_instr=0.
- Fill and drain: push 0x0200_8057 (vadd.vv), 0x0200_6007, 0x0A00_4057, 0x0000_7057 with rs1=0x100..0x103, out_ready=0 -> count=4, in_ready=0. Assert out_ready -> pops in order, rs1 0x100..0x103, count 4->0.
- Simultaneous push/pop at count=2: one cycle with both handshakes -> count stays 2, new entry is popped third.
- Illegal filter: push 0x0000_0033 (scalar add) -> in_ready=1, count unchanged, illegal=1 next cycle only, out_valid stays 0.
- Flush mid-stream: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. A subsequent push appears as the only entry.
- Wrap-around: 10 push/pop cycles at DEPTH=4 with a pattern instr=0x57|(i<<7) -> output order equals input order, no loss or duplication. With VIQ_BYPASS_EN, empty queue plus out_ready=1 -> out_valid in the same cycle as in_valid and count stays 0.
